// File: rtl/clint_mh_pkg.sv
// clint_mh_pkg: register map offsets, decode result type and byte-strobe merge
package clint_mh_pkg;

    localparam logic [15:0] MSIP_BASE  = 16'h0000;
    localparam logic [15:0] MTCMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_ADDR = 16'hBFF8;

    typedef enum logic [1:0] {
        DEC_MSIP,
        DEC_MTCMP,
        DEC_MTIME,
        DEC_ERR
    } dec_e;

    // Replace each byte of old_v with the matching byte of new_v where strb is set
    function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] r;
        for (int i = 0; i < 8; i++)
            r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/clint_mh_mtime.sv
// clint_mh_mtime: prescaled mtime counter where a software write beats the tick increment
module clint_mh_mtime
    import clint_mh_pkg::*;
#(
    parameter int TIME_W   = 64,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    output logic [TIME_W-1:0] mtime
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]     r_pre;
    logic [TIME_W-1:0] r_mtime;
    logic              w_tick;

    assign w_tick = (r_pre == PMAX);
    assign mtime  = r_mtime;

    // Prescaler runs 0..PRESCALE-1 regardless of software writes to mtime
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_pre <= '0;
        else
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end

    // A write with any strobe set replaces the increment; an all-zero strobe leaves the tick alone
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_mtime <= '0;
        else if (we && |wstrb)
            r_mtime <= TIME_W'(strb_merge(64'(r_mtime), wdata, wstrb));
        else if (w_tick)
            r_mtime <= r_mtime + 1'b1;
    end

endmodule

// File: rtl/clint_mh.sv
// clint_mh: multi-hart core-local interruptor with shared mtime and per-hart mtimecmp/msip
module clint_mh
    import clint_mh_pkg::*;
#(
    parameter int NUM_HARTS = 2,
    parameter int TIME_W    = 64,
    parameter int PRESCALE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [15:0]          req_addr,
    input  logic [63:0]          req_wdata,
    input  logic [7:0]           req_wstrb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_rdata,
    output logic                 rsp_err,
    input  logic [NUM_HARTS-1:0] mie,
    input  logic [NUM_HARTS-1:0] mtie,
    input  logic [NUM_HARTS-1:0] msie,
    output logic [NUM_HARTS-1:0] tint,
    output logic [NUM_HARTS-1:0] sint
);

    localparam logic [12:0] MSIP_W     = MSIP_BASE[15:3];
    localparam logic [12:0] MTCMP_W    = MTCMP_BASE[15:3];
    localparam logic [12:0] MTIME_W    = MTIME_ADDR[15:3];
    localparam logic [12:0] MSIP_WORDS = 13'((NUM_HARTS + 1) / 2);
    localparam logic [12:0] NH         = 13'(NUM_HARTS);

    logic [12:0]       w_word;
    logic [12:0]       w_msip_idx;
    logic [12:0]       w_mtcmp_idx;
    dec_e              w_dec;
    logic              w_hs;
    logic              w_wr;
    logic [63:0]       w_rd;
    logic [TIME_W-1:0] w_mtime;
    logic [TIME_W-1:0] w_cmp [NUM_HARTS];
    logic [NUM_HARTS-1:0] w_sip;
    logic              w_unused;
    logic              r_valid;
    logic [63:0]       r_rdata;
    logic              r_err;

    // Offsets below a region's base wrap to huge indices, so one compare bounds each region
    assign w_word      = req_addr[15:3];
    assign w_msip_idx  = w_word - MSIP_W;
    assign w_mtcmp_idx = w_word - MTCMP_W;
    assign w_dec       = (w_word == MTIME_W)    ? DEC_MTIME :
                         (w_msip_idx < MSIP_WORDS) ? DEC_MSIP :
                         (w_mtcmp_idx < NH)     ? DEC_MTCMP : DEC_ERR;
    assign w_unused    = ^req_addr[2:0];

    assign req_ready = rst_n & (!r_valid | rsp_ready);
    assign w_hs      = req_valid & req_ready;
    assign w_wr      = w_hs & req_we;
    assign rsp_valid = r_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    clint_mh_mtime #(
        .TIME_W   (TIME_W),
        .PRESCALE (PRESCALE)
    ) u_mtime (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (w_wr && w_dec == DEC_MTIME),
        .wdata (req_wdata),
        .wstrb (req_wstrb),
        .mtime (w_mtime)
    );

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic [TIME_W-1:0] r_cmp;
        logic              r_sip;
        logic              w_cmp_we;
        logic              w_sip_we;

        assign w_cmp_we = w_wr && w_dec == DEC_MTCMP && w_mtcmp_idx == 13'(h);
        assign w_sip_we = w_wr && w_dec == DEC_MSIP && w_msip_idx == 13'(h / 2)
                          && req_wstrb[4 * (h % 2)];

        // mtimecmp resets to all-ones so no timer interrupt fires before software sets it
        always_ff @(posedge clk) begin
            if (!rst_n)
                r_cmp <= '1;
            else if (w_cmp_we)
                r_cmp <= TIME_W'(strb_merge(64'(r_cmp), req_wdata, req_wstrb));
        end

        // Even harts live in bit 0 of their msip word, odd harts in bit 32
        always_ff @(posedge clk) begin
            if (!rst_n)
                r_sip <= 1'b0;
            else if (w_sip_we)
                r_sip <= req_wdata[32 * (h % 2)];
        end

        assign w_cmp[h] = r_cmp;
        assign w_sip[h] = r_sip;
        assign tint[h]  = (w_mtime >= r_cmp) & mie[h] & mtie[h];
        assign sint[h]  = r_sip & mie[h] & msie[h];
    end

    // Read data reflects register state before this edge's updates
    always_comb begin
        w_rd = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_dec == DEC_MTCMP && w_mtcmp_idx == 13'(h))
                w_rd = 64'(w_cmp[h]);
            if (w_dec == DEC_MSIP && w_msip_idx == 13'(h / 2))
                w_rd[32 * (h % 2)] = w_sip[h];
        end
        if (w_dec == DEC_MTIME)
            w_rd = 64'(w_mtime);
    end

    // Single response slot: load on handshake, hold until consumed, drop on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_hs) begin
            r_valid <= 1'b1;
            r_rdata <= (req_we || w_dec == DEC_ERR) ? '0 : w_rd;
            r_err   <= (w_dec == DEC_ERR);
        end else if (rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clint_mh.sv
// tb_clint_mh: directed self-checking bench for clint_mh (3 harts, PRESCALE=4)
module tb_clint_mh;

    localparam int NH = 3;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [15:0]   req_addr;
    logic [63:0]   req_wdata;
    logic [7:0]    req_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [63:0]   rsp_rdata;
    logic          rsp_err;
    logic [NH-1:0] mie;
    logic [NH-1:0] mtie;
    logic [NH-1:0] msie;
    logic [NH-1:0] tint;
    logic [NH-1:0] sint;

    int n_chk = 0;
    int n_err = 0;

    clint_mh #(
        .NUM_HARTS (NH),
        .TIME_W    (64),
        .PRESCALE  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mie       (mie),
        .mtie      (mtie),
        .msie      (msie),
        .tint      (tint),
        .sint      (sint)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; returns at the next negedge with the response visible
    task automatic do_req(input logic we, input logic [15:0] a, input logic [63:0] d,
                          input logic [7:0] s);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        #1 chk("req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic chk_rsp(input string tag, input logic [63:0] d, input logic e);
        chk({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".rdata"}, rsp_rdata, d);
        chk({tag, ".err"}, 64'(rsp_err), 64'(e));
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b1;
        mie       = '1;
        mtie      = '1;
        msie      = '1;
        repeat (3) @(negedge clk);
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.rsp_rdata", rsp_rdata, 64'd0);
        chk("rst.req_ready", 64'(req_ready), 64'd0);
        chk("rst.tint", 64'(tint), 64'd0);
        chk("rst.sint", 64'(sint), 64'd0);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        // mtime after k edges is k/4; read at edge 10 returns value before it (9/4)
        do_req(1'b0, 16'hBFF8, 64'd0, 8'h00);
        chk_rsp("mtime_rd10", 64'd2, 1'b0);
        chk("tint_reset_cmp", 64'(tint), 64'd0);
        do_req(1'b1, 16'h0000, 64'h0000_0001_0000_0001, 8'hF0);
        chk_rsp("msip_wr", 64'd0, 1'b0);
        chk("sint_msip1", 64'(sint), 64'b010);
        do_req(1'b0, 16'h0000, 64'd0, 8'h00);
        chk_rsp("msip_rd0", 64'h0000_0001_0000_0000, 1'b0);
        do_req(1'b1, 16'h0008, 64'h0000_0001_0000_0001, 8'hFF);
        chk("sint_msip2", 64'(sint), 64'b110);
        do_req(1'b0, 16'h0008, 64'd0, 8'h00);
        chk_rsp("msip_rd1", 64'd1, 1'b0);
        msie = 3'b011;
        #1 chk("sint_msie_gate", 64'(sint), 64'b010);
        do_req(1'b0, 16'h4018, 64'd0, 8'h00);
        chk_rsp("err_hart3", 64'd0, 1'b1);
        do_req(1'b0, 16'h1234, 64'd0, 8'h00);
        chk_rsp("err_1234", 64'd0, 1'b1);
        do_req(1'b1, 16'h0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        chk_rsp("err_msip_w2", 64'd0, 1'b1);
        do_req(1'b0, 16'h0000, 64'd0, 8'h00);
        chk_rsp("msip_after_err", 64'h0000_0001_0000_0000, 1'b0);
        do_req(1'b1, 16'h4008, 64'd20, 8'hFF);
        chk_rsp("cmp1_wr", 64'd0, 1'b0);
        chk("tint_before", 64'(tint), 64'd0);
        do_req(1'b1, 16'h4010, 64'h1111_2222_3333_4444, 8'h0F);
        do_req(1'b1, 16'h4010, 64'h0, 8'h00);
        chk_rsp("wstrb0_wr", 64'd0, 1'b0);
        do_req(1'b0, 16'h4010, 64'd0, 8'h00);
        chk_rsp("cmp2_partial", 64'hFFFF_FFFF_3333_4444, 1'b0);
        // now after edge 22; mtime reaches 20 at edge 80
        repeat (57) @(negedge clk);
        chk("tint_mtime19", 64'(tint), 64'd0);
        @(negedge clk);
        chk("tint_mtime20", 64'(tint), 64'b010);
        mtie = 3'b101;
        #1 chk("tint_mtie_off", 64'(tint), 64'd0);
        mtie = 3'b111;
        mie  = 3'b101;
        #1 chk("tint_mie_off", 64'(tint), 64'd0);
        mie = 3'b111;
        #1 chk("tint_restored", 64'(tint), 64'b010);
        do_req(1'b0, 16'h4008, 64'd0, 8'h00);
        chk_rsp("cmp1_rd", 64'd20, 1'b0);
        do_req(1'b0, 16'h4000, 64'd0, 8'h00);
        chk_rsp("cmp0_rd", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        // edge 83 writes all-ones (no tick), edge 84 ticks and wraps to 0
        do_req(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        chk("tint_all_ones", 64'(tint), 64'b111);
        do_req(1'b0, 16'hBFF8, 64'd0, 8'h00);
        chk_rsp("mtime_ones_rd", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("tint_wrapped", 64'(tint), 64'd0);
        do_req(1'b0, 16'hBFF8, 64'd0, 8'h00);
        chk_rsp("mtime_wrap_rd", 64'd0, 1'b0);
        repeat (2) @(negedge clk);
        // edge 88 is a tick: the write must store exactly 0x100
        do_req(1'b1, 16'hBFF8, 64'h100, 8'hFF);
        do_req(1'b0, 16'hBFF8, 64'd0, 8'h00);
        chk_rsp("mtime_wr_tick", 64'h100, 1'b0);
        repeat (2) @(negedge clk);
        do_req(1'b0, 16'hBFF8, 64'd0, 8'h00);
        chk_rsp("mtime_pre_inc", 64'h100, 1'b0);
        do_req(1'b0, 16'hBFF8, 64'd0, 8'h00);
        chk_rsp("mtime_post_inc", 64'h101, 1'b0);
        // accept one read, then stall the response with another request pending
        req_valid = 1'b1;
        req_addr  = 16'h4008;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_addr  = 16'h4000;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall.req_ready", 64'(req_ready), 64'd0);
            chk_rsp("stall", 64'd20, 1'b0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst2.rsp_rdata", rsp_rdata, 64'd0);
        chk("rst2.rsp_err", 64'(rsp_err), 64'd0);
        chk("rst2.req_ready", 64'(req_ready), 64'd0);
        chk("rst2.tint", 64'(tint), 64'd0);
        chk("rst2.sint", 64'(sint), 64'd0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        rst_n     = 1'b1;
        do_req(1'b0, 16'hBFF8, 64'd0, 8'h00);
        chk_rsp("rst2.mtime", 64'd0, 1'b0);
        do_req(1'b0, 16'h0000, 64'd0, 8'h00);
        chk_rsp("rst2.msip0", 64'd0, 1'b0);
        do_req(1'b0, 16'h0008, 64'd0, 8'h00);
        chk_rsp("rst2.msip1", 64'd0, 1'b0);
        do_req(1'b0, 16'h4008, 64'd0, 8'h00);
        chk_rsp("rst2.cmp1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        chk("rst2.tint_after", 64'(tint), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
